dpi_luma_crop: RTL and testbench



---
 rtl/dpi_luma_crop.sv | 131 +++++++++++++
 tb/tb_dpi_luma_crop.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_luma_crop.sv
// DPI capture front end: RGB666 pixels to 0..11 luma, cropped to a
// fixed window, re-emitted as the de/vsync/data stream for the sampler.
module dpi_luma_crop #(
    parameter int H_START  = 0,
    parameter int H_ACTIVE = 160,
    parameter int V_START  = 0,
    parameter int V_ACTIVE = 144,
    parameter int VS_POL   = 1,
    parameter int INVERT   = 0
) (
    input  logic       rst,
    input  logic       rgb_clk,
    input  logic       raw_de,
    input  logic       raw_vsync,
    input  logic [5:0] raw_r,
    input  logic [5:0] raw_g,
    input  logic [5:0] raw_b,
    output logic       rgb_de,
    output logic       rgb_vsync,
    output logic [3:0] rgb_data,
    output logic       short_frame
);

    localparam int H_END = H_START + H_ACTIVE;
    localparam int V_END = V_START + V_ACTIVE;

    logic        vs_n;
    logic        de_fall;
    logic        vs_rise;
    logic        h_ok;
    logic        v_ok;
    logic        v_below;
    logic        in_win;

    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        de_prev_q;
    logic        vs_prev_q;
    logic        short_q, short_d;

    logic [7:0]  sum1_q, sum1_d;
    logic        de1_q;
    logic        vs1_q;

    logic [9:0]  prod;
    logic [3:0]  luma_raw;
    logic [3:0]  luma;
    logic [3:0]  data_q, data_d;
    logic        de2_q;
    logic        vs2_q;

    assign vs_n    = (VS_POL != 0) ? raw_vsync : !raw_vsync;
    assign de_fall = de_prev_q & !raw_de;
    assign vs_rise = vs_n & !vs_prev_q;

    // Window test uses the counters before this cycle's update, so the
    // pixel on the bus is indexed by the pre-increment hcnt.
    assign h_ok    = (int'(hcnt_q) >= H_START) && (int'(hcnt_q) < H_END);
    assign v_ok    = (int'(vcnt_q) >= V_START) && (int'(vcnt_q) < V_END);
    assign v_below = int'(vcnt_q) < V_END;
    assign in_win  = raw_de & !vs_n & h_ok & v_ok;

    // Pixel/line counters and the sticky short-frame detector.
    always_comb begin
        hcnt_d  = '0;
        vcnt_d  = vcnt_q;
        short_d = short_q;
        if (raw_de) begin
            hcnt_d = (&hcnt_q) ? hcnt_q : hcnt_q + 11'd1;
        end
        if (vs_n) begin
            vcnt_d = '0;
        end else if (de_fall && !(&vcnt_q)) begin
            vcnt_d = vcnt_q + 10'd1;
        end
        if (vs_rise && v_below && (vcnt_q != '0)) begin
            short_d = 1'b1;
        end
    end

    // Weighted sum r+2g+b fits in 8 bits (max 252).
    assign sum1_d = {2'b00, raw_r} + {1'b0, raw_g, 1'b0} + {2'b00, raw_b};

    // Scale 0..252 onto 0..11 as (sum*3)>>6.
    assign prod     = {2'b00, sum1_q} + {1'b0, sum1_q, 1'b0};
    assign luma_raw = 4'(prod >> 6);
    assign luma     = (INVERT != 0) ? 4'd11 - luma_raw : luma_raw;
    assign data_d   = de1_q ? luma : 4'd0;

    // Counter and edge-detect state.
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            de_prev_q <= raw_de;
            vs_prev_q <= vs_n;
            short_q   <= short_d;
        end
    end

    // Two-stage pipeline: stage 1 sum/flags, stage 2 luma and outputs.
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            sum1_q <= '0;
            de1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            data_q <= '0;
            de2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            sum1_q <= sum1_d;
            de1_q  <= in_win;
            vs1_q  <= vs_n;
            data_q <= data_d;
            de2_q  <= de1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign rgb_de      = de2_q;
    assign rgb_vsync   = vs2_q;
    assign rgb_data    = data_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_dpi_luma_crop.sv
// Directed bench for dpi_luma_crop: four parameterisations share
// one stimulus bus; each scenario task checks its own outputs.
module tb_dpi_luma_crop;

    logic       rst;
    logic       rgb_clk;
    logic       raw_de;
    logic       raw_vsync;
    logic [5:0] raw_r;
    logic [5:0] raw_g;
    logic [5:0] raw_b;

    logic       de_d, vs_d, sf_d;
    logic [3:0] data_d;
    logic       de_i, vs_i, sf_i;
    logic [3:0] data_i;
    logic       de_h, vs_h, sf_h;
    logic [3:0] data_h;
    logic       de_v, vs_v, sf_v;
    logic [3:0] data_v;

    int n_chk;
    int n_fail;

    dpi_luma_crop u_dflt (
        .rst(rst), .rgb_clk(rgb_clk),
        .raw_de(raw_de), .raw_vsync(raw_vsync),
        .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b),
        .rgb_de(de_d), .rgb_vsync(vs_d),
        .rgb_data(data_d), .short_frame(sf_d)
    );

    dpi_luma_crop #(.VS_POL(0), .INVERT(1)) u_inv (
        .rst(rst), .rgb_clk(rgb_clk),
        .raw_de(raw_de), .raw_vsync(!raw_vsync),
        .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b),
        .rgb_de(de_i), .rgb_vsync(vs_i),
        .rgb_data(data_i), .short_frame(sf_i)
    );

    dpi_luma_crop #(.H_START(4), .H_ACTIVE(3)) u_h (
        .rst(rst), .rgb_clk(rgb_clk),
        .raw_de(raw_de), .raw_vsync(raw_vsync),
        .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b),
        .rgb_de(de_h), .rgb_vsync(vs_h),
        .rgb_data(data_h), .short_frame(sf_h)
    );

    dpi_luma_crop #(.V_START(2), .V_ACTIVE(2)) u_v (
        .rst(rst), .rgb_clk(rgb_clk),
        .raw_de(raw_de), .raw_vsync(raw_vsync),
        .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b),
        .rgb_de(de_v), .rgb_vsync(vs_v),
        .rgb_data(data_v), .short_frame(sf_v)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    // Present one input cycle; returns at the following falling edge.
    task automatic cyc(input logic de, input logic vs,
                       input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b);
        raw_de    = de;
        raw_vsync = vs;
        raw_r     = r;
        raw_g     = g;
        raw_b     = b;
        @(negedge rgb_clk);
    endtask

    task automatic vsync(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 6'd0, 6'd0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic lines(input int nl);
        for (int l = 0; l < nl; l++) begin
            cyc(1'b1, 1'b0, 6'd9, 6'd9, 6'd9);
            cyc(1'b1, 1'b0, 6'd9, 6'd9, 6'd9);
            cyc(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
        end
    endtask

    task automatic do_reset();
        raw_de = 1'b0; raw_vsync = 1'b0;
        raw_r = '0; raw_g = '0; raw_b = '0;
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        @(negedge rgb_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_de = 1'b1; raw_vsync = 1'b0;
        raw_r = 6'd63; raw_g = 6'd63; raw_b = 6'd63;
        @(negedge rgb_clk);
        @(negedge rgb_clk);
        @(negedge rgb_clk);
        n_chk++;
        if ({de_d, vs_d, data_d, sf_d, de_i, vs_i, data_i, sf_i,
             de_h, vs_h, data_h, sf_h, de_v, vs_v, data_v, sf_v} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h required all 0",
                     {de_d, vs_d, data_d, sf_d}, {de_i, vs_i, data_i, sf_i},
                     {de_h, vs_h, data_h, sf_h}, {de_v, vs_v, data_v, sf_v});
        end
        raw_de = 1'b0;
        #2 rst = 1'b0;
        @(negedge rgb_clk);
    endtask

    task automatic test_luma();
        logic [5:0] tr [5];
        logic [5:0] tg [5];
        logic [5:0] tb [5];
        logic [3:0] ed [5];
        logic [3:0] ei [5];
        tr = '{6'd63, 6'd0, 6'd32, 6'd10, 6'd0};
        tg = '{6'd63, 6'd0, 6'd0, 6'd20, 6'd63};
        tb = '{6'd63, 6'd0, 6'd0, 6'd30, 6'd0};
        ed = '{4'd11, 4'd0, 4'd1, 4'd3, 4'd5};
        ei = '{4'd0, 4'd11, 4'd10, 4'd8, 4'd6};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            cyc(1'b1, 1'b0, tr[t], tg[t], tb[t]);
            n_chk++;
            if ({de_d, de_i} !== 2'b00) begin
                n_fail++;
                $display("FAIL luma_latency[%0d]: de %b%b required 00",
                         t, de_d, de_i);
            end
            cyc(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
            n_chk++;
            if ({de_d, data_d} !== {1'b1, ed[t]}) begin
                n_fail++;
                $display("FAIL luma_dflt[%0d]: de=%b data=%0d required de=1 data=%0d",
                         t, de_d, data_d, ed[t]);
            end
            n_chk++;
            if ({de_i, data_i} !== {1'b1, ei[t]}) begin
                n_fail++;
                $display("FAIL luma_inv[%0d]: de=%b data=%0d required de=1 data=%0d",
                         t, de_i, data_i, ei[t]);
            end
            cyc(1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
            n_chk++;
            if ({de_d, data_d, de_i, data_i, de_h} !== 11'd0) begin
                n_fail++;
                $display("FAIL luma_idle[%0d]: got %b/%0d %b/%0d %b required all 0",
                         t, de_d, data_d, de_i, data_i, de_h);
            end
        end
    endtask

    task automatic test_h_window();
        int cnt;
        logic eh, ed1;
        cnt = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(i < 10, 1'b0, 6'd63, 6'd63, 6'd63);
            eh  = (i - 1 >= 4) && (i - 1 <= 6);
            ed1 = (i - 1 >= 0) && (i - 1 <= 9);
            if (de_h) cnt++;
            n_chk++;
            if ({de_h, data_h, de_d} !== {eh, eh ? 4'd11 : 4'd0, ed1}) begin
                n_fail++;
                $display("FAIL h_window[%0d]: h de=%b data=%0d dflt de=%b required %b/%0d/%b",
                         i, de_h, data_h, de_d, eh, eh ? 11 : 0, ed1);
            end
        end
        n_chk++;
        if (cnt !== 3) begin
            n_fail++;
            $display("FAIL h_window_count: got %0d required 3", cnt);
        end
    endtask

    task automatic test_v_window();
        int cnt;
        int exp_cnt;
        logic [3:0] evs [5];
        evs = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
        do_reset();
        vsync(2);
        for (int l = 0; l < 5; l++) begin
            cnt = 0;
            for (int p = 0; p < 5; p++) begin
                cyc(p < 3, 1'b0, 6'd63, 6'd63, 6'd63);
                if (de_v) begin
                    cnt++;
                    n_chk++;
                    if (data_v !== 4'd11) begin
                        n_fail++;
                        $display("FAIL v_window_data[%0d]: got %0d required 11",
                                 l, data_v);
                    end
                end
            end
            exp_cnt = (l == 2 || l == 3) ? 3 : 0;
            n_chk++;
            if (cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL v_window_line[%0d]: de cycles %0d required %0d",
                         l, cnt, exp_cnt);
            end
        end
        for (int j = 0; j < 5; j++) begin
            cyc(1'b0, j < 3, 6'd0, 6'd0, 6'd0);
            n_chk++;
            if ({vs_d, vs_i, vs_v} !== {3{evs[j][0]}}) begin
                n_fail++;
                $display("FAIL vsync_out[%0d]: got %b%b%b required %b",
                         j, vs_d, vs_i, vs_v, evs[j][0]);
            end
        end
        n_chk++;
        if ({sf_v, sf_d} !== 2'b01) begin
            n_fail++;
            $display("FAIL v_window_short: v=%b dflt=%b required v=0 dflt=1",
                     sf_v, sf_d);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        vsync(3);
        n_chk++;
        if ({sf_d, sf_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL short_first_vsync: got %b%b required 00", sf_d, sf_v);
        end
        lines(1);
        vsync(2);
        n_chk++;
        if ({sf_d, sf_v} !== 2'b11) begin
            n_fail++;
            $display("FAIL short_one_line: got %b%b required 11", sf_d, sf_v);
        end
        do_reset();
        vsync(2);
        lines(4);
        vsync(2);
        n_chk++;
        if ({sf_d, sf_v} !== 2'b10) begin
            n_fail++;
            $display("FAIL short_exact_window: got %b%b required 10", sf_d, sf_v);
        end
        lines(3);
        vsync(2);
        n_chk++;
        if (sf_v !== 1'b1) begin
            n_fail++;
            $display("FAIL short_three_lines: got %b required 1", sf_v);
        end
        lines(144);
        vsync(2);
        lines(150);
        vsync(2);
        n_chk++;
        if ({sf_d, sf_v} !== 2'b11) begin
            n_fail++;
            $display("FAIL short_sticky: got %b%b required 11", sf_d, sf_v);
        end
        do_reset();
        n_chk++;
        if ({sf_d, sf_v, sf_i} !== 3'b000) begin
            n_fail++;
            $display("FAIL short_cleared: got %b%b%b required 000",
                     sf_d, sf_v, sf_i);
        end
    endtask

    task automatic test_reset_mid_line();
        int cnt_d;
        int cnt_v;
        do_reset();
        cyc(1'b1, 1'b0, 6'd63, 6'd63, 6'd63);
        cyc(1'b1, 1'b0, 6'd63, 6'd63, 6'd63);
        cyc(1'b1, 1'b0, 6'd63, 6'd63, 6'd63);
        n_chk++;
        if ({de_d, data_d} !== {1'b1, 4'd11}) begin
            n_fail++;
            $display("FAIL mid_line_pre: de=%b data=%0d required 1/11",
                     de_d, data_d);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({de_d, data_d, de_i, data_i, vs_i} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_line_async: got %b/%0d %b/%0d %b required all 0",
                     de_d, data_d, de_i, data_i, vs_i);
        end
        raw_de = 1'b0;
        @(negedge rgb_clk);
        #2 rst = 1'b0;
        @(negedge rgb_clk);
        vsync(2);
        for (int l = 0; l < 4; l++) begin
            cnt_d = 0;
            cnt_v = 0;
            for (int p = 0; p < 5; p++) begin
                cyc(p < 3, 1'b0, 6'd32, 6'd0, 6'd0);
                if (de_d) cnt_d++;
                if (de_v) begin
                    cnt_v++;
                    n_chk++;
                    if (data_v !== 4'd1) begin
                        n_fail++;
                        $display("FAIL restart_data[%0d]: got %0d required 1",
                                 l, data_v);
                    end
                end
            end
            n_chk++;
            if (cnt_d !== 3 || cnt_v !== ((l >= 2) ? 3 : 0)) begin
                n_fail++;
                $display("FAIL restart_line[%0d]: dflt %0d v %0d required 3 and %0d",
                         l, cnt_d, cnt_v, (l >= 2) ? 3 : 0);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        raw_de = 1'b0; raw_vsync = 1'b0;
        raw_r = '0; raw_g = '0; raw_b = '0;
        test_reset();
        test_luma();
        test_h_window();
        test_v_window();
        test_short_frame();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
